bank_register: RTL and testbench



---
 rtl/bank_register_pkg.sv | 15 +
 rtl/bank_register.sv | 56 +++++
 tb/tb_bank_register.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bank_register_pkg.sv
// ---------------------------------------------------------------------------
// bank_register_pkg
// Shared register-file sizing and types. The decoder, ALU and writeback
// stages import these so that every register address and data bus in the
// datapath has one definition.
// ---------------------------------------------------------------------------
package bank_register_pkg;

   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 6;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : bank_register_pkg

// File: rtl/bank_register.sv
// ---------------------------------------------------------------------------
// bank_register
// General-purpose register file of 2**ADDR_W registers, each DATA_W bits wide.
// It has two combinational read ports and one synchronous write port.
// Register 0 is an ordinary writable register.
//
// Ports:
//   clk      system clock; the write happens on the rising edge
//   rst_n    asynchronous active-low reset; clears every register
//   RegLe1   read address, port 1
//   RegLe2   read address, port 2
//   RegEscr  write address
//   EscrReg  write enable, active-high
//   datain   write data
//   data1    contents of register RegLe1 (combinational)
//   data2    contents of register RegLe2 (combinational)
// ---------------------------------------------------------------------------
module bank_register
   import bank_register_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] RegLe1,
   input  logic [ADDR_W-1:0] RegLe2,
   input  logic [ADDR_W-1:0] RegEscr,
   input  logic              EscrReg,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2
);

   // DEPTH follows the address width so that every address is valid.
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_r [DEPTH];

   // Register storage: asynchronous clear, single write port on the rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (EscrReg) begin
         regs_r[RegEscr] <= datain;
      end
   end

   // Read ports are plain array lookups with no write-to-read bypass, so a
   // read of the register being written shows the old value until the edge.
   assign data1 = regs_r[RegLe1];
   assign data2 = regs_r[RegLe2];

endmodule : bank_register

// File: tb/tb_bank_register.sv
// ---------------------------------------------------------------------------
// tb_bank_register
// Self-checking bench for bank_register. A plain array holds the expected
// register contents. It is updated from the write rules: write on the
// rising edge when enabled, and clear everything on reset.
// ---------------------------------------------------------------------------
module tb_bank_register;

   logic        clk;
   logic        rst_n;
   logic [5:0]  RegLe1;
   logic [5:0]  RegLe2;
   logic [5:0]  RegEscr;
   logic        EscrReg;
   logic [31:0] datain;
   logic [31:0] data1;
   logic [31:0] data2;

   logic [31:0] model [64];
   int          n_cmp;
   int          n_bad;

   bank_register dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RegLe1  (RegLe1),
      .RegLe2  (RegLe2),
      .RegEscr (RegEscr),
      .EscrReg (EscrReg),
      .datain  (datain),
      .data1   (data1),
      .data2   (data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a write at the falling edge, let the rising edge take it, update the model.
   task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic en);
      @(negedge clk);
      RegEscr = addr;
      datain  = data;
      EscrReg = en;
      @(posedge clk);
      if (rst_n && en) model[addr] = data;
      #1;
   endtask

   // Compare both read ports against the model for the given addresses.
   task automatic read_pair(input string tag, input logic [5:0] a1, input logic [5:0] a2);
      RegLe1 = a1;
      RegLe2 = a2;
      #1;
      check_eq({tag, "_d1"}, data1, model[a1]);
      check_eq({tag, "_d2"}, data2, model[a2]);
   endtask

   initial begin
      logic [31:0] v;
      logic [5:0]  a, b;
      logic [31:0] d;
      logic        e;
      n_cmp   = 0;
      n_bad   = 0;
      foreach (model[i]) model[i] = 32'h0;

      // Reset with arbitrary addresses, checked before any clock edge.
      rst_n   = 1'b0;
      RegLe1  = 6'($urandom_range(0, 63));
      RegLe2  = 6'($urandom_range(0, 63));
      RegEscr = 6'd0;
      EscrReg = 1'b0;
      datain  = 32'h0;
      #2;
      check_eq("rst_async_d1", data1, 32'h0);
      check_eq("rst_async_d2", data2, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      read_pair("rst_rd_0_63", 6'd0, 6'd63);

      // Register 0 is writable.
      RegLe1 = 6'd0;
      RegLe2 = 6'd1;
      do_write(6'd0, 32'h0000_0001, 1'b1);
      check_eq("wr0_d1", data1, 32'h0000_0001);
      check_eq("wr0_d2", data2, 32'h0000_0000);
      do_write(6'd0, 32'hFFFF_FFFF, 1'b0);
      check_eq("wr0_hold_d1", data1, 32'h0000_0001);

      // A disabled write leaves the register untouched.
      RegLe1 = 6'd5;
      for (int k = 0; k < 4; k++) do_write(6'd5, 32'hDEAD_BEEF, 1'b0);
      check_eq("dis_wr_d1", data1, 32'h0000_0000);

      // Full sweep: write i*0x01010101 everywhere, then read pairs (i, 63-i).
      for (int i = 0; i < 64; i++) do_write(6'(i), 32'(i) * 32'h0101_0101, 1'b1);
      for (int i = 0; i < 64; i++) begin
         RegLe1 = 6'(i);
         RegLe2 = 6'(63 - i);
         #1;
         v = 32'(i) * 32'h0101_0101;
         check_eq($sformatf("sweep_d1_%0d", i), data1, v);
         v = 32'(63 - i) * 32'h0101_0101;
         check_eq($sformatf("sweep_d2_%0d", i), data2, v);
      end

      // Both ports on the same register.
      read_pair("same_reg", 6'd42, 6'd42);

      // Read-during-write: old value before the edge, new value after it.
      do_write(6'd10, 32'd7, 1'b1);
      @(negedge clk);
      RegLe1  = 6'd10;
      RegEscr = 6'd10;
      datain  = 32'd9;
      EscrReg = 1'b1;
      #1;
      check_eq("rdw_before", data1, 32'd7);
      @(posedge clk);
      model[10] = 32'd9;
      #1;
      check_eq("rdw_after", data1, 32'd9);

      // Randomized traffic: model checked both before and after each edge.
      for (int k = 0; k < 400; k++) begin
         a = 6'($urandom_range(0, 63));
         d = $urandom;
         e = 1'($urandom_range(0, 1));
         @(negedge clk);
         RegEscr = a;
         datain  = d;
         EscrReg = e;
         RegLe1  = ($urandom_range(0, 3) == 0) ? a : 6'($urandom_range(0, 63));
         RegLe2  = 6'($urandom_range(0, 63));
         #1;
         check_eq("rnd_pre_d1", data1, model[RegLe1]);
         check_eq("rnd_pre_d2", data2, model[RegLe2]);
         @(posedge clk);
         if (e) model[a] = d;
         #1;
         check_eq("rnd_post_d1", data1, model[RegLe1]);
         check_eq("rnd_post_d2", data2, model[RegLe2]);
      end

      // Asynchronous reset between edges, then a write attempted during reset.
      do_write(6'd20, 32'h1234_5678, 1'b1);
      do_write(6'd21, 32'h8765_4321, 1'b1);
      @(negedge clk);
      EscrReg = 1'b0;
      RegLe1  = 6'd20;
      RegLe2  = 6'd21;
      #1;
      check_eq("pre_rst_d1", data1, 32'h1234_5678);
      check_eq("pre_rst_d2", data2, 32'h8765_4321);
      #1;
      rst_n = 1'b0;
      foreach (model[i]) model[i] = 32'h0;
      #1;
      check_eq("mid_rst_d1", data1, 32'h0);
      check_eq("mid_rst_d2", data2, 32'h0);
      do_write(6'd20, 32'hCAFE_F00D, 1'b1);
      check_eq("rst_wr_d1", data1, 32'h0);
      @(negedge clk);
      EscrReg = 1'b0;
      rst_n   = 1'b1;
      for (int i = 0; i < 64; i += 2) read_pair("post_rst", 6'(i), 6'(i + 1));

      // A write works again after reset is released.
      RegLe1 = 6'd20;
      do_write(6'd20, 32'hCAFE_F00D, 1'b1);
      check_eq("post_rst_wr", data1, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bank_register
